// File: rtl/mux_gates_checker.sv
// mux_gates_checker: sweeps {a,b} through 00,01,10,11 for LOOPS sweeps,
// samples the gate block outputs after SETTLE_CYC cycles and compares them
// against the ideal inverter/AND/OR/NAND/NOR/XOR/XNOR truth table.
//
// state  | meaning
// IDLE   | waiting for start, a=b=0, busy low
// SETTLE | current vector held on a/b while the gate block settles
// CHECK  | compare sampled gate outputs against the expected vector
// DONE   | one-cycle end of run, done pulses, pass valid
module mux_gates_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int LOOPS      = 1,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       gate_o,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [6:0]       err_mask
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [1:0]       vec;
  logic [7:0]       loop_cnt;
  logic [3:0]       settle_cnt;
  logic [6:0]       gate_s;
  logic [6:0]       exp_gate;
  logic [6:0]       mism;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic [1:0]       vec_nxt;

  // Ideal gate outputs for the vector currently on a/b, and the resulting
  // per-bit mismatch plus the saturating error count for this vector.
  always_comb begin
    exp_gate    = {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    mism        = gate_s ^ exp_gate;
    err_cnt_nxt = err_cnt;
    if ((mism != 7'd0) && (err_cnt != CNT_MAX)) begin
      err_cnt_nxt = err_cnt + CNT_ONE;
    end
    vec_nxt = vec + 2'd1;
  end

  // Sequencer: stimulus, sampling, statistics and status flags.
  // gate_o is captured on the last SETTLE cycle so that a/b have been held
  // exactly SETTLE_CYC cycles when the sample is taken; CHECK compares it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 2'd0;
      loop_cnt   <= 8'd0;
      settle_cnt <= 4'd0;
      gate_s     <= 7'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      err_mask   <= 7'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            err_cnt    <= '0;
            err_mask   <= 7'd0;
            pass       <= 1'b0;
            vec        <= 2'd0;
            loop_cnt   <= 8'd0;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            gate_s <= gate_o;
            state  <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        CHECK: begin
          err_mask <= err_mask | mism;
          err_cnt  <= err_cnt_nxt;
          if (vec != 2'd3) begin
            vec        <= vec_nxt;
            a          <= vec_nxt[1];
            b          <= vec_nxt[0];
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end else if (loop_cnt != LOOP_LAST) begin
            loop_cnt   <= loop_cnt + 8'd1;
            vec        <= 2'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end else begin
            // pass uses the count including this last vector, so it is
            // already valid while done is high.
            a     <= 1'b0;
            b     <= 1'b0;
            pass  <= (err_cnt_nxt == '0);
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_gates_checker.md
Name: mux_gates_checker

Overview:
Self-checking stimulus/response stage wrapped around the mux-based gate block. It drives the gate block's a/b inputs upstream through all four input combinations and consumes its seven gate outputs (t..z) downstream. Each sample is compared against the ideal inverter/AND/OR/NAND/NOR/XOR/XNOR truth table, with error statistics accumulated per run. It is used for on-board and simulation self-test of the gate block.

Parameters:
SETTLE_CYC, 2, cycles a/b are held before gate outputs are sampled; legal range 1..15.
LOOPS, 1, number of full 4-vector sweeps per run; legal range 1..255.
CNT_W, 4, width of the error counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a run; sampled only in IDLE.
gate_o  input  7  gate block outputs: bit6=t, bit5=u, bit4=v, bit3=w, bit2=x, bit1=y, bit0=z.
a  output  1  stimulus to the gate block, registered.
b  output  1  stimulus to the gate block, registered.
busy  output  1  high from the cycle after start is accepted until DONE is exited.
done  output  1  single-cycle pulse at the end of a run.
pass  output  1  1 when the last completed run had zero failing vectors; held until the next start.
err_cnt  output  CNT_W  count of failing vectors in the current or last run; saturating.
err_mask  output  7  sticky OR of mismatching gate_o bits in the current or last run.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, err_mask=0, state=IDLE, vector index=0, loop count=0, settle counter=0. Reset takes effect immediately, including mid-run. No partial results are kept.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - a=b=0, busy=0.
  - If start=1, next edge: clear err_cnt, err_mask and pass; vec=0; loop=0; load {a,b}=vec; settle counter=SETTLE_CYC-1; go to SETTLE; busy=1.
- SETTLE: lasts exactly SETTLE_CYC cycles. The counter decrements each cycle; go to CHECK on the edge where the counter is 0.
- CHECK (1 cycle):
  - Sample gate_o and compute exp from the current a,b: t=~a, u=a&b, v=a|b, w=~(a&b), x=~(a|b), y=a^b, z=~(a^b).
  - mism = gate_o ^ exp; err_mask <= err_mask | mism.
  - If mism is nonzero, err_cnt increments by 1. It counts once per vector, not per bit, and saturates at all-ones with no wrap.
  - If vec<3: vec++, drive the new {a,b}, reload the counter, go to SETTLE.
  - If vec==3 and loop<LOOPS-1: loop++, vec=0, drive {a,b}=00, go to SETTLE.
  - If vec==3 and loop==LOOPS-1: go to DONE and drive a=b=0.
- Vector order: {a,b} = 00, 01, 10, 11, repeated LOOPS times.
- DONE (1 cycle):
  - done=1, busy=1.
  - pass <= (final err_cnt==0), including any increment from the last CHECK.
  - Next edge: IDLE, busy=0, done=0.
- Latency: if start is high in cycle 0 (IDLE), done is high in cycle 4*LOOPS*(SETTLE_CYC+1)+1. With defaults, that is cycle 13.
- start handling:
  - Ignored in SETTLE, CHECK and DONE.
  - If start is held high continuously, a new run begins on the edge after IDLE is re-entered. This gives back-to-back runs with one IDLE cycle between them.
- Statistics visibility: err_cnt and err_mask are readable live during a run and hold their final values after done until the next accepted start. pass reads 0 during a run.
- Timing assumption: gate_o is assumed combinational or pipelined by at most SETTLE_CYC-1 cycles relative to a/b. The checker does not detect latency violations; it reports them as mismatches.
- Widths: err_cnt is CNT_W bits. The vector index is 2 bits. The loop counter is 8 bits. The settle counter is 4 bits.

Test Plan:
1. Correct gate block, defaults, 1-cycle start pulse -> a/b show 00,01,10,11 (3 cycles each); done high in cycle 13 only; pass=1, err_cnt=0, err_mask=7'h00; busy high cycles 1..13.
2. Fault: gate_o[6] (t) stuck at 0 -> vectors with a=0 fail -> err_cnt=2, err_mask=7'b1000000, pass=0.
3. LOOPS=3, gate_o[1] (y) always inverted -> CNT_W=4: err_cnt=12, err_mask=7'b0000010; CNT_W=2: err_cnt saturates at 3 with no wrap; pass=0 in both cases.
4. start pulsed during SETTLE/CHECK -> ignored, done still lands in cycle 13. Then a run with a fault followed by a second start on a correct block -> second run clears stats and ends with pass=1, err_cnt=0. start held high -> runs repeat with exactly one IDLE cycle between DONE and the next busy.
5. rst asserted asynchronously mid-SETTLE of vector 2 -> a, b, busy, err_cnt, err_mask and pass go to 0 without waiting for a clock edge, and done never fires. After release, start -> a clean full run with pass=1.
6. SETTLE_CYC=1 with a correct combinational block -> done in cycle 9, pass=1. SETTLE_CYC=1 with a 1-cycle registered gate block -> mismatches occur and pass=0. SETTLE_CYC=2 with the same registered block -> pass=1.
